axi_lite_cmd_master: RTL
========================

Name: axi_lite_cmd_master

Overview:
- Single-outstanding AXI4-Lite master that turns simple host commands (read or write, address, data, strobe) into bus transactions.
- Sits directly upstream of the two-slave wrapper: slave 1 at 0x00–0x0F, slave 2 at 0x10–0x1F.
- Returns read data and response status to the host.
- Includes a per-transaction timeout so a hung slave cannot lock the host.

Parameters:
- DATA_WIDTH, 32, data bus width in bits (multiple of 8).
- ADDR_WIDTH, 8, byte address width.
- RESP_WIDTH, 3, width of bresp/rresp, matching the wrapper.
- TIMEOUT, 64, cycles allowed per transaction before abort (≥2).

Ports:
- m3_axi_aclk  in  1  clock; all logic on rising edge.
- m3_axi_areset  in  1  asynchronous, active-high reset.
- cmd_valid  in  1  host command valid.
- cmd_ready  out  1  master can accept a command.
- cmd_rw  in  1  1 = write, 0 = read.
- cmd_addr  in  ADDR_WIDTH  byte address.
- cmd_wdata  in  DATA_WIDTH  write data.
- cmd_wstrb  in  DATA_WIDTH/8  byte strobes.
- rsp_valid  out  1  result valid.
- rsp_ready  in  1  host accepts result.
- rsp_rdata  out  DATA_WIDTH  read data; 0 for writes.
- rsp_resp  out  RESP_WIDTH  bresp/rresp from the slave, or all-ones on timeout.
- rsp_timeout  out  1  transaction aborted by timeout.
- m3_axi_awaddr/awvalid/awready, wdata/wstrb/wvalid/wready, bresp/bvalid/bready, araddr/arvalid/arready, rdata/rresp/rvalid/rready: standard AXI-Lite master side.
  - Widths: ADDR_WIDTH, DATA_WIDTH, DATA_WIDTH/8, RESP_WIDTH.
  - Inputs: awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid. All others are outputs.

Behaviour:
- Reset values:
  - All valid/ready outputs 0, except cmd_ready = 1.
  - rsp_rdata, rsp_resp, rsp_timeout and all AXI address/data/strobe outputs = 0.
  - State = IDLE; timeout counter = 0.
- States: IDLE, WRITE, WRESP, RADDR, RDATA, RESP.
- IDLE:
  - cmd_ready = 1.
  - On cmd_valid & cmd_ready, register addr/wdata/wstrb.
  - cmd_rw = 1: assert awvalid and wvalid on the next cycle, go to WRITE.
  - cmd_rw = 0: assert arvalid on the next cycle, go to RADDR.
  - cmd_ready = 0 in every state other than IDLE.
- WRITE:
  - AW and W complete independently; each valid drops the cycle after its own handshake (tracked by aw_done and w_done).
  - When both are done, assert bready and go to WRESP.
  - Simultaneous AW and W handshakes in one cycle are legal and go directly to WRESP.
- WRESP: on bvalid & bready, capture bresp, set rsp_rdata = 0, drop bready, go to RESP.
- RADDR: on arvalid & arready, drop arvalid, assert rready, go to RDATA.
- RDATA: on rvalid & rready, capture rdata/rresp, drop rready, go to RESP.
- RESP:
  - rsp_valid = 1 with result stable until rsp_ready.
  - On rsp_valid & rsp_ready, go to IDLE.
  - Back-to-back commands: best case, cmd_ready is back high the cycle after rsp acceptance.
- AXI rules:
  - Valid never depends combinationally on ready.
  - Address, data and strobe are held stable while valid is high.
  - No combinational path from any input to any output.
- Latency: with slaves responding the same cycle, cmd accept → rsp_valid = 3 cycles for a write and 3 for a read.
- Timeout:
  - Counter clears on command acceptance and increments every cycle in WRITE/WRESP/RADDR/RDATA.
  - When it reaches TIMEOUT−1 with no completing handshake, all AXI valid/ready outputs drop.
  - Result is rsp_resp = all-ones, rsp_timeout = 1, rsp_rdata = 0; go to RESP.
  - A handshake completing in that same cycle wins over the timeout.
  - Timeout is a debug escape: a late slave response afterwards is ignored, and bready/rready stay 0.
- Reset mid-transaction: all outputs return to reset values immediately (asynchronously) and any in-flight command is dropped.
- Addresses are passed through unmodified; decode and DECERR are the slave wrapper's job.

Test Plan:
- Write 0x19 to address 0x10 with wstrb 0xF, slave ready immediately → one AW and one W beat with awaddr = 0x10; rsp_valid 3 cycles after accept, rsp_resp = 0, rsp_timeout = 0.
- Read address 0x18 after writing 0x22 there → arvalid one cycle, rready until rvalid; rsp_rdata = 0x22, rsp_resp = 0.
- Write with awready delayed 4 cycles and wready immediate → wvalid drops after 1 cycle, awvalid held 5 cycles with stable awaddr; bready asserts only after both handshakes.
- Hold rsp_ready = 0 for 10 cycles → rsp_valid and result stay stable; cmd_ready stays 0; completes the cycle rsp_ready rises.
- Slave never asserts arready, TIMEOUT = 8 → arvalid drops at cycle 8; rsp_resp = 3'b111, rsp_timeout = 1; a following write to 0x14 completes normally.
- Assert m3_axi_areset during WRESP → outputs return to reset values immediately; after release, a read of 0x1C completes normally.

Source files
------------

// File: rtl/axi_lite_cmd_master_if.sv
// AXI4-Lite bus between the command master and the two-slave wrapper.
// Master drives address/data/strobe/valid and the response readies.
interface axi_lite_cmd_master_if #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32,
  parameter int RESP_WIDTH = 3
);
  logic [ADDR_WIDTH-1:0]   awaddr;
  logic                    awvalid;
  logic                    awready;
  logic [DATA_WIDTH-1:0]   wdata;
  logic [DATA_WIDTH/8-1:0] wstrb;
  logic                    wvalid;
  logic                    wready;
  logic [RESP_WIDTH-1:0]   bresp;
  logic                    bvalid;
  logic                    bready;
  logic [ADDR_WIDTH-1:0]   araddr;
  logic                    arvalid;
  logic                    arready;
  logic [DATA_WIDTH-1:0]   rdata;
  logic [RESP_WIDTH-1:0]   rresp;
  logic                    rvalid;
  logic                    rready;

  modport master (
    output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport slave (
    input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/axi_lite_cmd_master.sv
// Single-outstanding AXI4-Lite master: host command in, one bus transaction out,
// result (data/resp/timeout flag) held for the host until accepted.
module axi_lite_cmd_master #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8,
  parameter int RESP_WIDTH = 3,
  parameter int TIMEOUT    = 64
) (
  input  logic                    m3_axi_aclk,
  input  logic                    m3_axi_areset,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic                    cmd_rw,
  input  logic [ADDR_WIDTH-1:0]   cmd_addr,
  input  logic [DATA_WIDTH-1:0]   cmd_wdata,
  input  logic [DATA_WIDTH/8-1:0] cmd_wstrb,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [DATA_WIDTH-1:0]   rsp_rdata,
  output logic [RESP_WIDTH-1:0]   rsp_resp,
  output logic                    rsp_timeout,
  axi_lite_cmd_master_if.master   m3_axi
);

  localparam int CNT_W = $clog2(TIMEOUT);

  typedef enum logic [2:0] {IDLE, WRITE, WRESP, RADDR, RDATA, RESP} state_t;

  state_t           state;
  logic             aw_done;
  logic             w_done;
  logic [CNT_W-1:0] count;

  logic aw_hs, w_hs, b_hs, ar_hs, r_hs;
  logic aw_fin, w_fin, timed_out;

  assign aw_hs     = m3_axi.awvalid & m3_axi.awready;
  assign w_hs      = m3_axi.wvalid  & m3_axi.wready;
  assign b_hs      = m3_axi.bvalid  & m3_axi.bready;
  assign ar_hs     = m3_axi.arvalid & m3_axi.arready;
  assign r_hs      = m3_axi.rvalid  & m3_axi.rready;
  assign aw_fin    = aw_done | aw_hs;
  assign w_fin     = w_done  | w_hs;
  assign timed_out = (count == CNT_W'(TIMEOUT - 1));

  // A completing handshake is always tested before the timeout, so it wins a tie.
  always_ff @(posedge m3_axi_aclk or posedge m3_axi_areset) begin
    if (m3_axi_areset) begin
      state          <= IDLE;
      aw_done        <= 1'b0;
      w_done         <= 1'b0;
      count          <= '0;
      cmd_ready      <= 1'b1;
      rsp_valid      <= 1'b0;
      rsp_rdata      <= '0;
      rsp_resp       <= '0;
      rsp_timeout    <= 1'b0;
      m3_axi.awaddr  <= '0;
      m3_axi.awvalid <= 1'b0;
      m3_axi.wdata   <= '0;
      m3_axi.wstrb   <= '0;
      m3_axi.wvalid  <= 1'b0;
      m3_axi.bready  <= 1'b0;
      m3_axi.araddr  <= '0;
      m3_axi.arvalid <= 1'b0;
      m3_axi.rready  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (cmd_valid && cmd_ready) begin
            cmd_ready <= 1'b0;
            count     <= '0;
            aw_done   <= 1'b0;
            w_done    <= 1'b0;
            if (cmd_rw) begin
              m3_axi.awaddr  <= cmd_addr;
              m3_axi.wdata   <= cmd_wdata;
              m3_axi.wstrb   <= cmd_wstrb;
              m3_axi.awvalid <= 1'b1;
              m3_axi.wvalid  <= 1'b1;
              state          <= WRITE;
            end else begin
              m3_axi.araddr  <= cmd_addr;
              m3_axi.arvalid <= 1'b1;
              state          <= RADDR;
            end
          end
        end

        WRITE: begin
          count <= count + 1'b1;
          if (aw_hs) begin
            m3_axi.awvalid <= 1'b0;
            aw_done        <= 1'b1;
          end
          if (w_hs) begin
            m3_axi.wvalid <= 1'b0;
            w_done        <= 1'b1;
          end
          if (aw_fin && w_fin) begin
            m3_axi.bready <= 1'b1;
            state         <= WRESP;
          end else if (timed_out) begin
            m3_axi.awvalid <= 1'b0;
            m3_axi.wvalid  <= 1'b0;
            rsp_rdata      <= '0;
            rsp_resp       <= '1;
            rsp_timeout    <= 1'b1;
            rsp_valid      <= 1'b1;
            state          <= RESP;
          end
        end

        WRESP: begin
          count <= count + 1'b1;
          if (b_hs) begin
            m3_axi.bready <= 1'b0;
            rsp_rdata     <= '0;
            rsp_resp      <= m3_axi.bresp;
            rsp_timeout   <= 1'b0;
            rsp_valid     <= 1'b1;
            state         <= RESP;
          end else if (timed_out) begin
            m3_axi.bready <= 1'b0;
            rsp_rdata     <= '0;
            rsp_resp      <= '1;
            rsp_timeout   <= 1'b1;
            rsp_valid     <= 1'b1;
            state         <= RESP;
          end
        end

        RADDR: begin
          count <= count + 1'b1;
          if (ar_hs) begin
            m3_axi.arvalid <= 1'b0;
            m3_axi.rready  <= 1'b1;
            state          <= RDATA;
          end else if (timed_out) begin
            m3_axi.arvalid <= 1'b0;
            rsp_rdata      <= '0;
            rsp_resp       <= '1;
            rsp_timeout    <= 1'b1;
            rsp_valid      <= 1'b1;
            state          <= RESP;
          end
        end

        RDATA: begin
          count <= count + 1'b1;
          if (r_hs) begin
            m3_axi.rready <= 1'b0;
            rsp_rdata     <= m3_axi.rdata;
            rsp_resp      <= m3_axi.rresp;
            rsp_timeout   <= 1'b0;
            rsp_valid     <= 1'b1;
            state         <= RESP;
          end else if (timed_out) begin
            m3_axi.rready <= 1'b0;
            rsp_rdata     <= '0;
            rsp_resp      <= '1;
            rsp_timeout   <= 1'b1;
            rsp_valid     <= 1'b1;
            state         <= RESP;
          end
        end

        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            cmd_ready <= 1'b1;
            state     <= IDLE;
          end
        end

        default: begin
          state     <= IDLE;
          cmd_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule
